// File: rtl/tree_router_node.sv
// rtl/tree_router_node.sv - tree interconnect node: per-input FIFOs, address routing, per-output round-robin register stage
// Optional per-output forward counters with TREE_ROUTER_STATS_EN.
module tree_router_node #(
    parameter int WIDTH       = 11,
    parameter int ADDR_W      = 3,
    parameter int NUM_CHILD   = 2,
    parameter int SUB_W       = 2,
    parameter int NODE_PREFIX = 0,
    parameter int IS_ROOT     = 0,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           parent_in_data,
    input  logic                       parent_in_valid,
    output logic                       parent_in_ready,
    output logic [WIDTH-1:0]           parent_out_data,
    output logic                       parent_out_valid,
    input  logic                       parent_out_ready,
    input  logic [NUM_CHILD*WIDTH-1:0] child_in_data,
    input  logic [NUM_CHILD-1:0]       child_in_valid,
    output logic [NUM_CHILD-1:0]       child_in_ready,
    output logic [NUM_CHILD*WIDTH-1:0] child_out_data,
    output logic [NUM_CHILD-1:0]       child_out_valid,
    input  logic [NUM_CHILD-1:0]       child_out_ready
`ifdef TREE_ROUTER_STATS_EN
    ,
    output logic [(NUM_CHILD+1)*16-1:0] stat_fwd_count
`endif
);

    localparam int NUM_IN  = NUM_CHILD + 1;
    localparam int CHILD_W = $clog2(NUM_CHILD);
    localparam int IDX_W   = $clog2(NUM_IN);
    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int PFX_W   = (ADDR_W > SUB_W) ? (ADDR_W - SUB_W) : 1;
    localparam logic [PFX_W-1:0] PFX = PFX_W'(NODE_PREFIX);

    logic [WIDTH-1:0]  in_data [NUM_IN];
    logic [NUM_IN-1:0] in_valid;
    logic [NUM_IN-1:0] in_ready;
    logic [NUM_IN-1:0] head_valid;
    logic [NUM_IN-1:0] pop;
    logic [WIDTH-1:0]  head [NUM_IN];
    logic [IDX_W-1:0]  route [NUM_IN];

    logic [WIDTH-1:0]  out_data [NUM_IN];
    logic [NUM_IN-1:0] out_valid;
    logic [NUM_IN-1:0] out_ready;
    logic [NUM_IN-1:0] can_load;
    logic [NUM_IN-1:0] gnt_any;
    logic [IDX_W-1:0]  gnt_idx [NUM_IN];
    logic [IDX_W-1:0]  last_grant [NUM_IN];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic             full;
        logic             go_up;

        if (i < NUM_CHILD) begin : g_child
            assign in_data[i]        = child_in_data[i*WIDTH +: WIDTH];
            assign in_valid[i]       = child_in_valid[i];
            assign child_in_ready[i] = in_ready[i];
        end else begin : g_parent
            assign in_data[i]      = parent_in_data;
            assign in_valid[i]     = parent_in_valid;
            assign parent_in_ready = in_ready[i];
        end

        assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        assign head_valid[i] = (wr_ptr != rd_ptr);
        assign head[i]       = mem[rd_ptr[AW-1:0]];

        if (i == NUM_CHILD && IS_ROOT != 0) begin : g_no_parent
            assign in_ready[i] = 1'b0;
        end else begin : g_rdy
            assign in_ready[i] = !reset && !full;
        end

        // Only child traffic can climb; the parent link always descends.
        if (i < NUM_CHILD && IS_ROOT == 0 && SUB_W < ADDR_W) begin : g_up
            assign go_up = (head[i][WIDTH-1 -: PFX_W] != PFX);
        end else begin : g_down
            assign go_up = 1'b0;
        end

        assign route[i] = go_up ? IDX_W'(NUM_CHILD)
                                : IDX_W'(head[i][WIDTH-1-(ADDR_W-SUB_W) -: CHILD_W]);

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (in_valid[i] && in_ready[i]) begin
                    mem[wr_ptr[AW-1:0]] <= in_data[i];
                    wr_ptr              <= wr_ptr + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    for (genvar o = 0; o < NUM_CHILD; o++) begin : g_cout
        assign child_out_data[o*WIDTH +: WIDTH] = out_data[o];
        assign child_out_valid[o]               = out_valid[o];
        assign out_ready[o]                     = child_out_ready[o];
    end
    assign parent_out_data   = out_data[NUM_CHILD];
    assign parent_out_valid  = (IS_ROOT == 0) && out_valid[NUM_CHILD];
    assign out_ready[NUM_CHILD] = parent_out_ready;

    // Each head requests exactly one output, so at most one grant can pop any FIFO.
    always_comb begin
        logic [IDX_W-1:0] c_idx;
        c_idx    = '0;
        pop      = '0;
        gnt_any  = '0;
        can_load = '0;
        for (int o = 0; o < NUM_IN; o++) begin
            gnt_idx[o]  = last_grant[o];
            can_load[o] = !out_valid[o] || out_ready[o];
            for (int k = 1; k <= NUM_IN; k++) begin
                c_idx = IDX_W'((int'(last_grant[o]) + k) % NUM_IN);
                if (!gnt_any[o] && can_load[o] && head_valid[c_idx] && route[c_idx] == IDX_W'(o)) begin
                    gnt_any[o] = 1'b1;
                    gnt_idx[o] = c_idx;
                end
            end
            if (gnt_any[o]) begin
                pop[gnt_idx[o]] = 1'b1;
            end
        end
    end

`ifdef TREE_ROUTER_STATS_EN
    logic [15:0] fwd_cnt [NUM_IN];
    for (genvar o = 0; o < NUM_IN; o++) begin : g_stat
        assign stat_fwd_count[o*16 +: 16] = fwd_cnt[o];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            for (int o = 0; o < NUM_IN; o++) begin
                out_data[o]   <= '0;
                last_grant[o] <= IDX_W'(NUM_IN - 1);
`ifdef TREE_ROUTER_STATS_EN
                fwd_cnt[o]    <= '0;
`endif
            end
        end else begin
            for (int o = 0; o < NUM_IN; o++) begin
                if (gnt_any[o]) begin
                    out_data[o]   <= head[gnt_idx[o]];
                    out_valid[o]  <= 1'b1;
                    last_grant[o] <= gnt_idx[o];
                end else if (out_ready[o]) begin
                    out_valid[o]  <= 1'b0;
                end
`ifdef TREE_ROUTER_STATS_EN
                if (out_valid[o] && out_ready[o] && fwd_cnt[o] != 16'hFFFF) begin
                    fwd_cnt[o] <= fwd_cnt[o] + 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_tree_router_node.sv
// tb/tb_tree_router_node.sv - scoreboard bench for tree_router_node (2 children, depth 4)
module tb_tree_router_node;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] parent_in_data;
    logic        parent_in_valid;
    logic        parent_in_ready;
    logic [10:0] parent_out_data;
    logic        parent_out_valid;
    logic        parent_out_ready;
    logic [21:0] child_in_data;
    logic [1:0]  child_in_valid;
    logic [1:0]  child_in_ready;
    logic [21:0] child_out_data;
    logic [1:0]  child_out_valid;
    logic [1:0]  child_out_ready;
`ifdef TREE_ROUTER_STATS_EN
    logic [47:0] stat_fwd_count;
`endif

    always #5 clk = ~clk;

    tree_router_node #(
        .WIDTH(11), .ADDR_W(3), .NUM_CHILD(2), .SUB_W(2),
        .NODE_PREFIX(0), .IS_ROOT(0), .DEPTH(4)
    ) dut (
`ifdef TREE_ROUTER_STATS_EN
        .stat_fwd_count  (stat_fwd_count),
`endif
        .clk             (clk),
        .reset           (reset),
        .parent_in_data  (parent_in_data),
        .parent_in_valid (parent_in_valid),
        .parent_in_ready (parent_in_ready),
        .parent_out_data (parent_out_data),
        .parent_out_valid(parent_out_valid),
        .parent_out_ready(parent_out_ready),
        .child_in_data   (child_in_data),
        .child_in_valid  (child_in_valid),
        .child_in_ready  (child_in_ready),
        .child_out_data  (child_out_data),
        .child_out_valid (child_out_valid),
        .child_out_ready (child_out_ready)
    );

    typedef struct packed {
        logic [31:0] t_exp;
        logic [10:0] data;
    } exp_t;

    exp_t        exp_q [3][$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cnt [3];
    int          hs_cnt [3];
    int          hs_first [3];
    int          hs_last [3];
    logic [2:0]  ovalid;
    logic [2:0]  oready;
    logic [10:0] odata [3];

    assign ovalid   = {parent_out_valid, child_out_valid};
    assign oready   = {parent_out_ready, child_out_ready};
    assign odata[0] = child_out_data[10:0];
    assign odata[1] = child_out_data[21:11];
    assign odata[2] = parent_out_data;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            for (int o = 0; o < 3; o++) begin
                if (ovalid[o] && oready[o]) begin
                    if (hs_cnt[o] == 0) hs_first[o] = cyc;
                    hs_last[o] = cyc;
                    hs_cnt[o]++;
                    checks++;
                    if (exp_q[o].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out%0d: got %h, required no packet", o, odata[o]);
                    end else begin
                        mon_e = exp_q[o].pop_front();
                        if (odata[o] !== mon_e.data) begin
                            errors++;
                            $display("FAIL data_out%0d: got %h, required %h", o, odata[o], mon_e.data);
                        end
                        if (mon_e.t_exp != 0) begin
                            checks++;
                            if (cyc != int'(mon_e.t_exp)) begin
                                errors++;
                                $display("FAIL latency_out%0d: valid at cycle %0d, required %0d", o, cyc, mon_e.t_exp);
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic int exp_port(input int src, input logic [10:0] d);
        if (src < 2 && d[10] != 1'b0) return 2;
        return int'(d[9]);
    endfunction

    function automatic logic src_ready(input int src);
        if (src == 2) return parent_in_ready;
        return child_in_ready[src];
    endfunction

    task automatic set_in(input int src, input logic [10:0] d, input logic v);
        if (src == 2) begin
            parent_in_data  = d;
            parent_in_valid = v;
        end else begin
            child_in_data[src*11 +: 11] = d;
            child_in_valid[src]         = v;
        end
    endtask

    task automatic send(input int src, input logic [10:0] d, input bit push, input bit lat);
        int   t;
        bit   done;
        exp_t e;
        t    = 0;
        done = 1'b0;
        set_in(src, d, 1'b1);
        while (!done) begin
            @(negedge clk);
            if (src_ready(src)) begin
                acc_cnt[src]++;
                if (push) begin
                    e.data  = d;
                    e.t_exp = lat ? 32'(cyc + 2) : 32'd0;
                    exp_q[exp_port(src, d)].push_back(e);
                end
                done = 1'b1;
            end else begin
                t++;
                if (t > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout src%0d: data %h not accepted, required acceptance within 200 cycles", src, d);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        set_in(src, 11'h0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
            errors++;
            $display("FAIL drain_%s: pending %0d/%0d/%0d packets, required 0/0/0",
                     name, exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    initial begin
        exp_t e;
        reset           = 1'b1;
        parent_in_data  = '0;
        parent_in_valid = 1'b0;
        child_in_data   = '0;
        child_in_valid  = '0;
        child_out_ready = 2'b11;
        parent_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc_cnt[i] = 0; hs_cnt[i] = 0; hs_first[i] = 0; hs_last[i] = 0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(ovalid), 32'h0);
        check("reset_child_in_ready", 32'(child_in_ready), 32'h0);
        check("reset_parent_in_ready", 32'(parent_in_ready), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'({parent_in_ready, child_in_ready}), 32'h7);

        // Route decode and parent downlink, one packet at a time
        @(posedge clk); #1;
        send(0, 11'h1A5, 1'b1, 1'b1);
        send(0, 11'h3A5, 1'b1, 1'b1);
        send(1, 11'h5A5, 1'b1, 1'b1);
        send(2, 11'h7FF, 1'b1, 1'b1);
        wait_drain("route");

        // Contention on child_out[1]: grants alternate child0, parent
        hs_cnt[1] = 0;
        for (int k = 0; k < 8; k++) begin
            e.t_exp = 32'd0;
            e.data  = {3'b010, 8'(k)};
            exp_q[1].push_back(e);
            e.data  = {3'b011, 8'(8'h80 + k)};
            exp_q[1].push_back(e);
        end
        @(posedge clk); #1;
        fork
            begin
                for (int k = 0; k < 8; k++) send(0, {3'b010, 8'(k)}, 1'b0, 1'b0);
            end
            begin
                for (int k = 0; k < 8; k++) send(2, {3'b011, 8'(8'h80 + k)}, 1'b0, 1'b0);
            end
        join
        wait_drain("contention");
        check("contention_count", 32'(hs_cnt[1]), 32'd16);
        check("contention_span", 32'(hs_last[1] - hs_first[1]), 32'd15);

        // Backpressure: child_out[0] stalled while child1 streams 6 packets
        @(posedge clk); #1;
        child_out_ready[0] = 1'b0;
        acc_cnt[1] = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) send(1, {3'b000, 8'(8'h40 + k)}, 1'b1, 1'b0);
            end
            begin
                repeat (12) @(posedge clk);
                @(negedge clk);
                check("bp_accepted", 32'(acc_cnt[1]), 32'd5);
                check("bp_child1_ready", 32'(child_in_ready[1]), 32'h0);
                check("bp_out0_valid_held", 32'(child_out_valid[0]), 32'h1);
                @(posedge clk);
                #1 child_out_ready[0] = 1'b1;
            end
        join
        wait_drain("backpressure");

        // Reset with packets buffered: nothing stale may emerge afterwards
        @(posedge clk); #1;
        child_out_ready = 2'b00;
        parent_out_ready = 1'b0;
        send(0, 11'h101, 1'b1, 1'b0);
        send(0, 11'h102, 1'b1, 1'b0);
        send(0, 11'h103, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_out_valid", 32'(ovalid), 32'h0);
        check("midreset_in_ready", 32'({parent_in_ready, child_in_ready}), 32'h0);
`ifdef TREE_ROUTER_STATS_EN
        check("midreset_stats", 32'(stat_fwd_count[31:0] | 32'(stat_fwd_count[47:32])), 32'h0);
`endif
        for (int o = 0; o < 3; o++) exp_q[o].delete();
        @(posedge clk);
        #1 reset = 1'b0;
        child_out_ready = 2'b11;
        parent_out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("after_reset_out_valid", 32'(ovalid), 32'h0);
        check("after_reset_ready", 32'({parent_in_ready, child_in_ready}), 32'h7);

`ifdef TREE_ROUTER_STATS_EN
        @(posedge clk); #1;
        for (int k = 0; k < 65540; k++) send(0, {3'b000, 8'(k)}, 1'b1, 1'b0);
        wait_drain("stats");
        check("stats_child0_sat", 32'(stat_fwd_count[15:0]), 32'hFFFF);
        check("stats_child1", 32'(stat_fwd_count[31:16]), 32'h0);
        check("stats_parent", 32'(stat_fwd_count[47:32]), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
